// File: rtl/cam_cfg_sequencer_if.sv
// SCCB write request/acknowledge channel between the camera config sequencer and the SCCB master.
interface cam_cfg_sequencer_if;
  logic       req;
  logic [7:0] addr;
  logic [7:0] data;
  logic       ack;
  logic       err;

  modport master (output req, addr, data, input ack, err);
  modport slave  (input req, addr, data, output ack, err);
endinterface

// File: rtl/cam_cfg_sequencer.sv
// Camera bring-up: walks a {addr,data} ROM issuing SCCB writes (with ms delays and NACK retries),
// then drops SKIP_FRAMES frames before enabling pixel capture.
module cam_cfg_sequencer #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TABLE_LEN   = 64,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned SKIP_FRAMES = 2,
  parameter logic [63:0][15:0] ROM = '{
    0: 16'h1280, 1: 16'hFF0A, 2: 16'h1204, 3: 16'h1100, 4: 16'h0C00, 5: 16'h3E00,
    6: 16'h8C00, 7: 16'h0400, 8: 16'h40D0, 9: 16'h3A04, 10: 16'h1418, 11: 16'h4F40,
    12: 16'h5034, 13: 16'h510C, 14: 16'h5217, 15: 16'h5329, 16: 16'h5440, 17: 16'h581E,
    18: 16'h3DC0, 19: 16'hFF01, 20: 16'h1711, 21: 16'h1861, 22: 16'h3292, 23: 16'h1903,
    24: 16'h1A7B, 25: 16'h0300, default: 16'hFFFF}
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_cam_i,
  input  logic                vsync_i,
  cam_cfg_sequencer_if.master sccb,
  output logic                busy_o,
  output logic                capture_en_o,
  output logic                error_o,
  output logic [5:0]          idx_o
);
  localparam int unsigned DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned SW  = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [5:0]  LAST       = 6'(TABLE_LEN - 1);
  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [7:0]  DELAY_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DELAY, S_SKIP, S_DONE, S_ERROR
  } state_t;

  localparam state_t END_STATE = (SKIP_FRAMES == 0) ? S_DONE : S_SKIP;

  state_t          state, state_d;
  logic [5:0]      idx, idx_d;
  logic [RW-1:0]   retry, retry_d;
  logic [15:0]     entry, entry_d;
  logic [TW-1:0]   tick_cnt, tick_d;
  logic [7:0]      ms_cnt, ms_d;
  logic [SW-1:0]   skip_cnt, skip_d;
  logic            start_q, start_edge;
  logic            vs_meta, vs_sync, vs_q;
  logic            vs_rise, tick, req;
  logic [15:0]     rom_word;
  state_t          adv_state;
  logic [5:0]      adv_idx;

  assign rom_word = ROM[idx];
  assign vs_rise  = vs_sync & ~vs_q;
  assign tick     = (tick_cnt == TW'(DIV - 1));

  // Moving past the last table slot ends the walk instead of wrapping idx.
  assign adv_state = (idx == LAST) ? END_STATE : S_FETCH;
  assign adv_idx   = (idx == LAST) ? idx : idx + 6'd1;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    retry_d = retry;
    entry_d = entry;
    tick_d  = '0;
    ms_d    = ms_cnt;
    skip_d  = skip_cnt;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_edge) begin
          state_d = S_FETCH;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      S_FETCH: begin
        entry_d = rom_word;
        ms_d    = '0;
        skip_d  = '0;
        if (rom_word == END_MARK)              state_d = END_STATE;
        else if (rom_word[15:8] != DELAY_ADDR) state_d = S_ISSUE;
        else if (rom_word[7:0] != 8'd0)        state_d = S_DELAY;
        else begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      S_ISSUE, S_WAIT: begin
        state_d = S_WAIT;
        if (sccb.ack) begin
          if (!sccb.err) begin
            retry_d = '0;
            state_d = adv_state;
            idx_d   = adv_idx;
          end else if (retry < RW'(MAX_RETRY)) begin
            // Re-fetching the same entry gives the mandatory idle cycle before re-issue.
            retry_d = retry + RW'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_DELAY: begin
        tick_d = tick ? '0 : tick_cnt + TW'(1);
        if (tick) begin
          if (ms_cnt == entry[7:0] - 8'd1) begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end else begin
            ms_d = ms_cnt + 8'd1;
          end
        end
      end
      S_SKIP: begin
        if (vs_rise) begin
          if (skip_cnt == SW'(SKIP_FRAMES - 1)) state_d = S_DONE;
          else                                  skip_d  = skip_cnt + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      idx        <= '0;
      retry      <= '0;
      entry      <= '0;
      tick_cnt   <= '0;
      ms_cnt     <= '0;
      skip_cnt   <= '0;
      start_q    <= 1'b0;
      start_edge <= 1'b0;
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      retry      <= retry_d;
      entry      <= entry_d;
      tick_cnt   <= tick_d;
      ms_cnt     <= ms_d;
      skip_cnt   <= skip_d;
      start_q    <= start_cam_i;
      start_edge <= start_cam_i & ~start_q;
      vs_meta    <= vsync_i;
      vs_sync    <= vs_meta;
      vs_q       <= vs_sync;
    end
  end

  // Outputs decode straight from state so reset drops req on the very next cycle.
  assign req          = (state == S_ISSUE) || (state == S_WAIT);
  assign sccb.req     = req;
  assign sccb.addr    = req ? entry[15:8] : 8'h00;
  assign sccb.data    = req ? entry[7:0]  : 8'h00;
  assign busy_o       = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign capture_en_o = (state == S_DONE);
  assign error_o      = (state == S_ERROR);
  assign idx_o        = idx;
endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Randomised scoreboard bench: a table-walking reference model predicts every SCCB request.
module tb_cam_cfg_sequencer;
  localparam int MAX_RETRY = 3;
  localparam logic [63:0][15:0] TB_ROM = '{
    0: 16'h1280, 1: 16'hFF0A, 2: 16'h3A04, 3: 16'h1711, 4: 16'hFF00,
    5: 16'h1861, 6: 16'hFF03, 7: 16'h3245, default: 16'hFFFF};

  typedef struct {
    logic [5:0]  idx;
    logic [15:0] word;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, vsync = 1'b0;
  logic busy, cap, err_flag;
  logic [5:0] idx;

  cam_cfg_sequencer_if sif();

  cam_cfg_sequencer #(
    .CLK_HZ(1000), .TABLE_LEN(64), .MAX_RETRY(MAX_RETRY), .SKIP_FRAMES(2), .ROM(TB_ROM)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_cam_i(start), .vsync_i(vsync), .sccb(sif),
    .busy_o(busy), .capture_en_o(cap), .error_o(err_flag), .idx_o(idx)
  );

  always #5 clk = ~clk;

  int   vectors = 0, miscompares = 0;
  int   cyc = 0, last_ack_cyc = 0, n_seen = 0;
  bit   resp_en = 1'b1;
  exp_t exp_q[$];
  bit   err_q[$];
  int   gaps[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_rng(string name, int v, int lo, int hi);
    vectors++;
    if (v < lo || v > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
    end
  endfunction

  // Reference model: walk the table, each write entry needs k NACKs then one ACK;
  // more than MAX_RETRY NACKs aborts the whole bring-up.
  task automatic plan(input int mode, output bit exp_err, output int n_exp);
    logic [15:0] w;
    int k;
    exp_err = 1'b0;
    n_exp   = 0;
    for (int i = 0; i < 64; i++) begin
      w = TB_ROM[i];
      if (w == 16'hFFFF) break;
      if (w[15:8] == 8'hFF) continue;
      k = 0;
      if (mode == 1 && i == 2) k = 2;
      if (mode == 2 && i == 2) k = MAX_RETRY + 1;
      if (mode == 3) begin
        case ($urandom_range(9, 0))
          6, 7:    k = 1;
          8:       k = MAX_RETRY;
          9:       k = MAX_RETRY + 1;
          default: k = 0;
        endcase
      end
      for (int a = 0; a <= MAX_RETRY && a <= k; a++) begin
        exp_q.push_back('{idx: 6'(i), word: w});
        err_q.push_back(a < k);
        n_exp++;
      end
      if (k > MAX_RETRY) begin
        exp_err = 1'b1;
        break;
      end
    end
  endtask

  always @(posedge clk) cyc++;

  // Responder: acks each request after a random wait, NACK bit taken from the plan.
  initial begin
    sif.ack = 1'b0;
    sif.err = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && sif.req) begin
        repeat ($urandom_range(19, 1)) @(negedge clk);
        sif.ack = 1'b1;
        sif.err = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
        @(negedge clk);
        sif.ack = 1'b0;
        sif.err = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new request and watches the handshake.
  logic        req_prev = 1'b0;
  logic [15:0] held = '0;
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      if (sif.ack && req_prev) begin
        chk("req_fall_after_ack", sif.req, 1'b0);
        last_ack_cyc = cyc;
      end
      if (sif.req && !req_prev) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got %0h, expected no request", {sif.addr, sif.data});
        end else begin
          e = exp_q.pop_front();
          chk("req_word", {sif.addr, sif.data}, e.word);
          chk("req_idx", idx, e.idx);
        end
        n_seen++;
        gaps.push_back(cyc - last_ack_cyc);
        held = {sif.addr, sif.data};
      end else if (sif.req) begin
        chk("req_stable", {sif.addr, sif.data}, held);
      end
    end
    req_prev = sif.req;
  end

  task automatic pulse_start(input bit vs_pulse);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("lat_req_c1", sif.req, 1'b0);
    @(negedge clk);
    chk("restart_busy", busy, 1'b1);
    chk("restart_cap", cap, 1'b0);
    chk("restart_err", err_flag, 1'b0);
    chk("restart_idx", idx, 6'd0);
    chk("lat_req_c2", sif.req, 1'b0);
    @(negedge clk);
    chk("lat_req_c3", sif.req, 1'b1);
    chk("first_addr_data", {sif.addr, sif.data}, 16'h1280);
    if (vs_pulse) begin
      vsync = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic do_run(input int mode);
    bit exp_err;
    int n_exp, t;
    gaps.delete();
    n_seen = 0;
    plan(mode, exp_err, n_exp);
    pulse_start(1'b1);
    t = 0;
    if (exp_err) begin
      while (busy && t < 3000) begin @(negedge clk); t++; end
      chk("err_end_timeout", t < 3000, 1'b1);
      chk("err_flag", err_flag, 1'b1);
      chk("err_cap", cap, 1'b0);
      chk("err_busy", busy, 1'b0);
    end else begin
      while ((exp_q.size() != 0 || err_q.size() != 0 || sif.req) && t < 3000) begin
        @(negedge clk); t++;
      end
      chk("cfg_end_timeout", t < 3000, 1'b1);
      repeat (4) @(negedge clk);
      chk("skip_busy", busy, 1'b1);
      chk("skip_cap0", cap, 1'b0);
      vsync = 1'b1; repeat (6) @(negedge clk);
      chk("cap_after_edge1", cap, 1'b0);
      vsync = 1'b0; repeat (4) @(negedge clk);
      vsync = 1'b1; repeat (6) @(negedge clk);
      chk("cap_after_edge2", cap, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("done_err", err_flag, 1'b0);
      vsync = 1'b0;
    end
    chk("req_count", n_seen, n_exp);
    chk("scoreboard_drained", exp_q.size(), 0);
    err_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", sif.req, 1'b0);
    chk("rst_addr_data", {sif.addr, sif.data}, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cap", cap, 1'b0);
    chk("rst_err", err_flag, 1'b0);
    chk("rst_idx", idx, 6'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean run; request gaps reveal the delay entries (1 ms = 1 cycle here).
    do_run(0);
    if (gaps.size() >= 5) begin
      chk_rng("delay_10ms_gap", gaps[1] - gaps[2], 9, 11);
      chk_rng("delay_0ms_gap",  gaps[3] - gaps[2], -1, 1);
      chk_rng("delay_3ms_gap",  gaps[4] - gaps[2], 2, 4);
    end else begin
      chk("gap_samples", gaps.size(), 5);
    end

    do_run(1);
    do_run(2);
    for (int r = 0; r < 5; r++) do_run(3);

    // Reset while a write is outstanding; a late ack must be ignored.
    resp_en = 1'b0;
    exp_q.push_back('{idx: 6'd0, word: 16'h1280});
    pulse_start(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_req", sif.req, 1'b0);
    chk("rstwait_busy", busy, 1'b0);
    chk("rstwait_idx", idx, 6'd0);
    rst = 1'b0;
    @(negedge clk) sif.ack = 1'b1;
    @(negedge clk) sif.ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_ack_req", sif.req, 1'b0);
    chk("late_ack_busy", busy, 1'b0);
    chk("late_ack_cap", cap, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
